// File: rtl/bcd_ctrl_pkg.sv
// Shared types and helpers for the BCD counter controller.
// Optional down-count support is enabled with BCD_CTRL_DOWN_EN.
package bcd_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   function automatic logic is_bcd(input logic [3:0] nib);
      return nib <= BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter cascade; steps when i_step and i_carry_in are both high.
// With BCD_CTRL_DOWN_EN defined, i_dir selects decrement (1) or increment (0).
module bcd_digit
   import bcd_ctrl_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_step,
   input  logic       i_carry_in,
   input  logic       i_clear,
`ifdef BCD_CTRL_DOWN_EN
   input  logic       i_dir,
`endif
   output logic [3:0] o_digit,
   output logic       o_carry_out
);

   logic [3:0] digit_q, digit_d;
   logic       at_limit;

`ifdef BCD_CTRL_DOWN_EN
   assign at_limit = i_dir ? (digit_q == BCD_MIN) : (digit_q == BCD_MAX);
`else
   assign at_limit = (digit_q == BCD_MAX);
`endif

   always_comb begin
      digit_d = digit_q;
      if (i_clear) begin
         digit_d = BCD_MIN;
      end else if (i_step && i_carry_in) begin
`ifdef BCD_CTRL_DOWN_EN
         if (i_dir) digit_d = at_limit ? BCD_MAX : digit_q - 4'd1;
         else       digit_d = at_limit ? BCD_MIN : digit_q + 4'd1;
`else
         digit_d = at_limit ? BCD_MIN : digit_q + 4'd1;
`endif
      end
      // Never let a non-BCD value into the register.
      if (!is_bcd(digit_d)) digit_d = BCD_MIN;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) digit_q <= BCD_MIN;
      else          digit_q <= digit_d;
   end

   assign o_digit     = digit_q;
   assign o_carry_out = i_carry_in && at_limit;

endmodule

// File: rtl/bcd_count_ctrl.sv
// Start/stop/clear sequencer, prescaler and target compare for a cascade of BCD digits.
// Defining BCD_CTRL_DOWN_EN adds i_down for BCD down-counting.
module bcd_count_ctrl
   import bcd_ctrl_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned PRESCALE = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic                  i_stop,
   input  logic                  i_clear,
   input  logic                  i_tgt_valid,
   output logic                  o_tgt_ready,
   input  logic [4*DIGITS-1:0]   i_tgt,
`ifdef BCD_CTRL_DOWN_EN
   input  logic                  i_down,
`endif
   output logic [4*DIGITS-1:0]   o_count,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_wrap,
   output logic                  o_tgt_err
);

   localparam int unsigned W            = 4 * DIGITS;
   localparam logic [15:0] PRESC_RELOAD = 16'(PRESCALE - 1);

   state_e         state_q, state_d;
   logic [15:0]    presc_q, presc_d;
   logic [W-1:0]   tgt_q, tgt_d;
   logic           done_q, done_d;
   logic           wrap_q, wrap_d;
   logic           err_q, err_d;
   logic           step, dir_now, tgt_ok;
   logic [DIGITS:0] carry;
   logic [W-1:0]   count, count_nxt;

`ifdef BCD_CTRL_DOWN_EN
   logic dir_q, dir_d;
   assign dir_now = dir_q;
`else
   assign dir_now = 1'b0;
`endif

   assign carry[0] = 1'b1;

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_digit u_digit (
         .i_clk      (i_clk),
         .i_rst_n    (i_rst_n),
         .i_step     (step),
         .i_carry_in (carry[k]),
         .i_clear    (i_clear),
`ifdef BCD_CTRL_DOWN_EN
         .i_dir      (dir_now),
`endif
         .o_digit    (count[4*k +: 4]),
         .o_carry_out(carry[k+1])
      );
   end

   // Post-step value, needed so o_done is registered together with the new count.
   always_comb begin
      for (int k = 0; k < DIGITS; k++) begin : b_nxt
         logic [3:0] nib;
         nib = count[4*k +: 4];
         if (carry[k]) begin
            if (dir_now) nib = (nib == BCD_MIN) ? BCD_MAX : nib - 4'd1;
            else         nib = (nib == BCD_MAX) ? BCD_MIN : nib + 4'd1;
         end
         count_nxt[4*k +: 4] = nib;
      end
   end

   always_comb begin
      tgt_ok = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (!is_bcd(i_tgt[4*k +: 4])) tgt_ok = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      tgt_d   = tgt_q;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
      err_d   = 1'b0;
      step    = 1'b0;
`ifdef BCD_CTRL_DOWN_EN
      dir_d   = dir_q;
`endif
      if (i_tgt_valid && o_tgt_ready) begin
         if (tgt_ok) tgt_d = i_tgt;
         else        err_d = 1'b1;
      end
      if (i_clear) begin
         state_d = IDLE;
         presc_d = PRESC_RELOAD;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (i_stop) begin
                  state_d = IDLE;
               end else if (i_start) begin
                  state_d = RUN;
                  presc_d = PRESC_RELOAD;
`ifdef BCD_CTRL_DOWN_EN
                  dir_d   = i_down;
`endif
               end
            end
            RUN: begin
               if (presc_q == '0) begin
                  step    = 1'b1;
                  presc_d = PRESC_RELOAD;
                  wrap_d  = carry[DIGITS];
                  if (count_nxt == tgt_q) begin
                     done_d  = 1'b1;
                     state_d = DONE;
                  end
               end else begin
                  presc_d = presc_q - 16'd1;
               end
               if (i_stop) state_d = HOLD;
            end
            HOLD: begin
               if (i_stop) begin
                  state_d = IDLE;
               end else if (i_start) begin
                  state_d = RUN;
`ifdef BCD_CTRL_DOWN_EN
                  dir_d   = i_down;
`endif
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         presc_q <= '0;
         tgt_q   <= '0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef BCD_CTRL_DOWN_EN
         dir_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         tgt_q   <= tgt_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
`ifdef BCD_CTRL_DOWN_EN
         dir_q   <= dir_d;
`endif
      end
   end

   assign o_count     = count;
   assign o_busy      = (state_q == RUN) || (state_q == HOLD);
   assign o_tgt_ready = (state_q == IDLE) || (state_q == DONE);
   assign o_done      = done_q;
   assign o_wrap      = wrap_q;
   assign o_tgt_err   = err_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench: two-digit counters, one stepping every clock (a_*) and one with PRESCALE=4 (b_*).
module tb_bcd_count_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       a_start, a_stop, a_clear, a_tgt_valid, a_tgt_ready;
   logic [7:0] a_tgt, a_count;
   logic       a_busy, a_done, a_wrap, a_tgt_err;
`ifdef BCD_CTRL_DOWN_EN
   logic       a_down;
   logic       b_down;
`endif
   logic       b_start, b_stop, b_clear, b_tgt_valid, b_tgt_ready;
   logic [7:0] b_tgt, b_count;
   logic       b_busy, b_done, b_wrap, b_tgt_err;

   int n_vec  = 0;
   int n_miss = 0;

   bcd_count_ctrl #(.DIGITS(2), .PRESCALE(1)) u_dut_a (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (a_start),
      .i_stop     (a_stop),
      .i_clear    (a_clear),
      .i_tgt_valid(a_tgt_valid),
      .o_tgt_ready(a_tgt_ready),
      .i_tgt      (a_tgt),
`ifdef BCD_CTRL_DOWN_EN
      .i_down     (a_down),
`endif
      .o_count    (a_count),
      .o_busy     (a_busy),
      .o_done     (a_done),
      .o_wrap     (a_wrap),
      .o_tgt_err  (a_tgt_err)
   );

   bcd_count_ctrl #(.DIGITS(2), .PRESCALE(4)) u_dut_b (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (b_start),
      .i_stop     (b_stop),
      .i_clear    (b_clear),
      .i_tgt_valid(b_tgt_valid),
      .o_tgt_ready(b_tgt_ready),
      .i_tgt      (b_tgt),
`ifdef BCD_CTRL_DOWN_EN
      .i_down     (b_down),
`endif
      .o_count    (b_count),
      .o_busy     (b_busy),
      .o_done     (b_done),
      .o_wrap     (b_wrap),
      .o_tgt_err  (b_tgt_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic a_pulse_start();
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
   endtask

   task automatic a_load(input logic [7:0] t);
      a_tgt_valid = 1'b1;
      a_tgt       = t;
      tick();
      a_tgt_valid = 1'b0;
   endtask

   task automatic a_run_until_done(input int limit, output int steps);
      steps = 0;
      do begin
         tick();
         steps++;
      end while (!a_done && steps < limit);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int steps;
      logic [7:0] seq [8];
      rst_n = 1'b0;
      a_start = 0; a_stop = 0; a_clear = 0; a_tgt_valid = 0; a_tgt = '0;
      b_start = 0; b_stop = 0; b_clear = 0; b_tgt_valid = 0; b_tgt = '0;
`ifdef BCD_CTRL_DOWN_EN
      a_down = 0; b_down = 0;
`endif
      #2;
      check_eq("reset count", 32'(a_count), 32'h00);
      check_eq("reset ready", 32'(a_tgt_ready), 32'd1);
      check_eq("reset busy", 32'(a_busy), 32'd0);
      check_eq("reset done", 32'(a_done | a_wrap | a_tgt_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Prescaled run with hold and resume.
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (i == 3) check_eq("b before first step", 32'(b_count), 32'h00);
         if (i == 4) check_eq("b first step", 32'(b_count), 32'h01);
      end
      b_stop = 1'b1;
      tick();
      b_stop = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check_eq("b frozen in hold", 32'(b_count), 32'h01);
      check_eq("b busy in hold", 32'(b_busy), 32'd1);
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      tick();
      check_eq("b resume +1", 32'(b_count), 32'h01);
      tick();
      check_eq("b resume +2 step", 32'(b_count), 32'h02);

      // Count 00..12 against target 12.
      a_load(8'h12);
      check_eq("load 12 err", 32'(a_tgt_err), 32'd0);
      a_pulse_start();
      check_eq("start busy", 32'(a_busy), 32'd1);
      check_eq("start ready low", 32'(a_tgt_ready), 32'd0);
      check_eq("start count", 32'(a_count), 32'h00);
      for (int k = 1; k <= 12; k++) begin
         tick();
         check_eq($sformatf("up count %0d", k), 32'(a_count), 32'(to_bcd(k)));
         check_eq($sformatf("up done %0d", k), 32'(a_done), (k == 12) ? 32'd1 : 32'd0);
      end
      tick();
      check_eq("done one cycle", 32'(a_done), 32'd0);
      check_eq("busy after done", 32'(a_busy), 32'd0);
      check_eq("hold at target", 32'(a_count), 32'h12);

      // Preset to 97, then wrap through 00 to 05.
      a_load(8'h97);
      a_pulse_start();
      a_run_until_done(200, steps);
      check_eq("reach 97 done", 32'(a_done), 32'd1);
      check_eq("reach 97 steps", 32'(steps), 32'd85);
      check_eq("reach 97 count", 32'(a_count), 32'h97);
      a_load(8'h05);
      a_pulse_start();
      seq = '{8'h98, 8'h99, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      for (int i = 0; i < 8; i++) begin
         tick();
         check_eq($sformatf("wrap seq %0d", i), 32'(a_count), 32'(seq[i]));
         check_eq($sformatf("wrap flag %0d", i), 32'(a_wrap), (i == 2) ? 32'd1 : 32'd0);
         check_eq($sformatf("wrap done %0d", i), 32'(a_done), (i == 7) ? 32'd1 : 32'd0);
      end

      // Invalid target rejected; target 05 kept, so a full wrap is needed.
      a_stop = 1'b1;
      tick();
      a_stop = 1'b0;
      a_load(8'h1A);
      check_eq("bad tgt err", 32'(a_tgt_err), 32'd1);
      tick();
      check_eq("bad tgt err clears", 32'(a_tgt_err), 32'd0);
      a_pulse_start();
      a_run_until_done(150, steps);
      check_eq("kept tgt done", 32'(a_done), 32'd1);
      check_eq("kept tgt steps", 32'(steps), 32'd100);
      check_eq("kept tgt count", 32'(a_count), 32'h05);
      a_load(8'h19);
      check_eq("good tgt err", 32'(a_tgt_err), 32'd0);
      check_eq("load in done stays", 32'(a_tgt_ready & ~a_busy), 32'd1);
      a_pulse_start();
      a_run_until_done(150, steps);
      check_eq("new tgt steps", 32'(steps), 32'd14);
      check_eq("new tgt count", 32'(a_count), 32'h19);

      // Clear beats stop and start in the same cycle.
      a_pulse_start();
      tick();
      tick();
      check_eq("pre clear count", 32'(a_count), 32'h21);
      a_clear = 1'b1; a_stop = 1'b1; a_start = 1'b1;
      tick();
      a_clear = 1'b0; a_stop = 1'b0; a_start = 1'b0;
      check_eq("clear count", 32'(a_count), 32'h00);
      check_eq("clear idle", 32'(a_busy), 32'd0);
      check_eq("clear no pulse", 32'(a_done | a_wrap), 32'd0);
      check_eq("clear ready", 32'(a_tgt_ready), 32'd1);
      tick();
      check_eq("clear stays", 32'(a_count), 32'h00);

      // Asynchronous reset mid-run.
      a_pulse_start();
      for (int i = 0; i < 3; i++) tick();
      check_eq("pre reset count", 32'(a_count), 32'h03);
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("async reset count", 32'(a_count), 32'h00);
      check_eq("async reset busy", 32'(a_busy), 32'd0);
      check_eq("async reset b count", 32'(b_count), 32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

`ifdef BCD_CTRL_DOWN_EN
      a_load(8'h97);
      a_down = 1'b1;
      a_pulse_start();
      a_down = 1'b0;
      tick();
      check_eq("down 99", 32'(a_count), 32'h99);
      check_eq("down wrap", 32'(a_wrap), 32'd1);
      tick();
      check_eq("down 98", 32'(a_count), 32'h98);
      check_eq("down wrap once", 32'(a_wrap), 32'd0);
      tick();
      check_eq("down 97", 32'(a_count), 32'h97);
      check_eq("down done", 32'(a_done), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
Controller and sequencer for a cascade of DIGITS BCD digit counters, forming a multi-digit decimal counter.
- Accepts start, stop and clear commands.
- Takes a BCD target over a valid/ready handshake.
- Paces increments with a prescaler.
- Pulses o_done when the count reaches the target.
- Sits between a host or timer front-end and the display or decode logic that consumes o_count.

Parameters:
DIGITS, 4, number of BCD digits (1..8); count width is 4*DIGITS.
PRESCALE, 1, i_clk cycles per count step (1..65535); 1 means one step per clock.

Ports:
i_clk  input  1  clock, all state on rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_start  input  1  start/resume command, single-cycle pulse.
i_stop  input  1  pause/abort command, single-cycle pulse.
i_clear  input  1  synchronous clear of count, prescaler and FSM.
i_tgt_valid  input  1  target word valid.
o_tgt_ready  output  1  target accepted this cycle if valid; high only in IDLE or DONE.
i_tgt  input  4*DIGITS  BCD target, digit 0 in bits [3:0].
o_count  output  4*DIGITS  current BCD count, registered.
o_busy  output  1  high in RUN or HOLD.
o_done  output  1  one-cycle pulse when count becomes equal to target.
o_wrap  output  1  one-cycle pulse when count rolls from all-9 to all-0.
o_tgt_err  output  1  one-cycle pulse when an offered target contains a nibble >9.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - state IDLE; count 0; target 0; prescaler 0.
  - all outputs 0, except o_tgt_ready = 1.
- FSM states: IDLE, RUN, HOLD, DONE.
- Command priority in one cycle: i_clear > i_stop > i_start.
- i_clear, any state: count <= 0, prescaler <= PRESCALE-1, state <= IDLE. Target is kept. No done/wrap pulse.
- IDLE:
  - i_start -> RUN, prescaler <= PRESCALE-1.
  - i_stop is ignored.
- RUN:
  - Prescaler decrements each cycle.
  - At 0, it reloads PRESCALE-1 and the count steps +1 in BCD.
  - Digit k increments when all lower digits are 9; each digit 9 wraps to 0.
  - i_stop -> HOLD.
- HOLD:
  - Count and prescaler are frozen.
  - i_start -> RUN, resuming with the prescaler value retained.
  - i_stop -> IDLE; the count is kept.
- DONE:
  - Count holds at the target.
  - i_start -> RUN; the next match needs a full 10^DIGITS-step cycle.
  - i_stop -> IDLE.
- Step/done rules:
  - The first step is exactly PRESCALE cycles after the edge that enters RUN.
  - Match is checked on the post-step value only. A count equal to the target at start does not trigger; a full wrap is required.
  - On a step producing count==target: state <= DONE and o_done = 1 for one cycle, registered with the new count.
  - On a step from all-9: o_wrap = 1 for one cycle. Wrap and done may pulse together when the target is 0.
- Target handshake:
  - Transfer occurs when i_tgt_valid && o_tgt_ready.
  - If any nibble >9: target unchanged and o_tgt_err pulses next cycle. The transfer still completes, so there is no stall.
  - A load in DONE does not change state.
- i_clear with a simultaneous target load: both take effect.
- Counts never take non-BCD values. The internal digit logic must guarantee this even if a step and a clear collide; clear wins.

Optional Feature:
BCD_CTRL_DOWN_EN.
- Defined:
  - Adds input port i_down (1 bit), sampled on the edge that accepts i_start (IDLE/HOLD/DONE -> RUN).
  - When the sampled value is 1, steps decrement in BCD: digit 0 wraps to 9 with a borrow.
  - o_wrap pulses on all-0 -> all-9.
  - Done and match rules are unchanged.
- Undefined: no i_down port; up-count only.

Decomposition:
- Package bcd_ctrl_pkg holds:
  - state enum/localparams (IDLE=2'd0, RUN=2'd1, HOLD=2'd2, DONE=2'd3);
  - BCD_MAX=4'd9 and BCD_MIN=4'd0;
  - a function checking that a nibble is valid BCD.
- Sub-module bcd_digit: one 4-bit BCD digit with inputs step, carry_in, clear (and dir under the macro), and outputs digit and carry_out.
  - Instantiated DIGITS times via generate.
  - The controller owns the FSM, prescaler, target register and compare.

Test Plan:
1. DIGITS=2, PRESCALE=1: load tgt=8'h12, pulse start -> o_count steps 00,01..12; o_done pulses once on the 12 cycle; o_busy drops; o_count holds 12.
2. DIGITS=2, tgt=8'h05, count preset to 97 via a prior run: start -> 98, 99, then 00 with o_wrap pulse, ..., then 05 with o_done.
3. PRESCALE=4: start, then stop after 6 cycles, hold 10 cycles, start -> count freezes at 01 during HOLD; next step occurs 2 cycles after resume.
4. i_tgt=8'h1A with valid in IDLE -> o_tgt_err pulse; target stays previous; a following 8'h19 is accepted.
5. Same-cycle i_clear+i_stop+i_start in RUN -> IDLE, count 00, no o_done/o_wrap; i_rst_n low mid-run -> immediate async zeroing.
6. With BCD_CTRL_DOWN_EN: i_down=1, start from 00, tgt=8'h97 -> 99 with o_wrap, 98, 97 with o_done.
